tgen_fetch_ot: RTL and testbench
================================

Name: tgen_fetch_ot

Overview:
- Parametrised fetch-side traffic generator for the instruction-cache testbench; next generation of the single-outstanding 128-bit generator.
- Drives the cache fetch port with sequential, LFSR-random or mixed address streams.
- Keeps up to MAX_OUTSTANDING granted requests in flight and checks every returned line against an address-derived golden pattern.
- Reports transaction count, error count and end-of-test.

Parameters:
FETCH_ADDR_WIDTH, 32, fetch address width
FETCH_DATA_WIDTH, 128, fetch line width; multiple of 32, >=32; BYTES = FETCH_DATA_WIDTH/8
MAX_OUTSTANDING, 4, max granted-but-not-returned requests; >=1; depth of the expected-address FIFO
N_TRANS, 1024, requests issued per run
ADDR_MASK, 32'h0000_0FF0, address bits allowed to vary (random and wrap region)
LFSR_SEED, 32'hACE1_2345, LFSR reset value; nonzero

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
fetch_enable_i  in  1  run/pause
mode_i  in  2  00 sequential, 01 random, 10 mixed, 11 treated as 00; sampled on IDLE->RUN only
base_addr_i  in  FETCH_ADDR_WIDTH  first address for modes 00/10; sampled on IDLE->RUN
fetch_req_o  out  1  request
fetch_addr_o  out  FETCH_ADDR_WIDTH  request address
fetch_gnt_i  in  1  grant
fetch_rvalid_i  in  1  response valid, in order
fetch_rdata_i  in  FETCH_DATA_WIDTH  response line
trans_cnt_o  out  32  granted requests
resp_cnt_o  out  32  responses received
err_cnt_o  out  16  mismatches plus unexpected responses; saturates at 16'hFFFF
err_o  out  1  sticky; set on the first error
eoc_o  out  1  end of test; sticky
busy_o  out  1  state is RUN or DRAIN

Behaviour:
- Reset values:
  - State IDLE.
  - fetch_req_o = 0; fetch_addr_o = 0.
  - All counters 0; err_o = 0; eoc_o = 0.
  - LFSR = LFSR_SEED; FIFO empty; outstanding = 0.
- Reset mid-run discards all state. Responses arriving after reset hit an empty FIFO and are counted as unexpected.
- States:
  - IDLE: fetch_enable_i=1 -> RUN. Load the first address: base_addr_i for modes 00/10; LFSR & ADDR_MASK for mode 01.
  - RUN: issue requests. When the N_TRANS-th grant occurs -> DRAIN.
  - DRAIN: no requests. When outstanding==0 -> DONE (can take 0 cycles if the last response arrives with the last grant? No: outstanding is registered, so wait until it reads 0).
  - DONE: eoc_o=1, busy_o=0. Stays until reset. Responses arriving in DONE are unexpected errors.
- Request rule: fetch_req_o is registered. It rises when all of the following hold:
  - state RUN, fetch_enable_i=1;
  - issued < N_TRANS;
  - registered outstanding < MAX_OUTSTANDING.
- A response in the same cycle does not free a slot until the next cycle.
- Handshake: once fetch_req_o=1, fetch_req_o and fetch_addr_o hold stable until the fetch_gnt_i cycle, even if fetch_enable_i drops. Deasserting fetch_enable_i only pauses new requests.
- On grant:
  - Push fetch_addr_o into the FIFO; outstanding +1; trans_cnt +1.
  - Compute the next address; the LFSR steps once.
  - Back-to-back requests are allowed: req may stay high with a new address in the cycle after the grant, if the slot rule permits.
- Next address, with wrap w(a) = (a & ~ADDR_MASK) | ((a + BYTES) & ADDR_MASK):
  - Mode 00: w(addr).
  - Mode 01: next LFSR & ADDR_MASK.
  - Mode 10: LFSR[3:0]==0 ? LFSR & ADDR_MASK : w(addr).
- LFSR: 32-bit Fibonacci, taps 32,22,2,1, shifts left, feedback into bit 0. Advances only on a grant.
- On fetch_rvalid_i:
  - Pop the FIFO; outstanding -1; resp_cnt +1.
  - Expected word k (k = 0..FETCH_DATA_WIDTH/32-1) = (popped_addr & ~(BYTES-1)) + 4k, mod 2^32.
  - Any word mismatch -> err_cnt +1 (one per response), err_o=1.
- rvalid with an empty FIFO: no pop; err_cnt +1; err_o=1.
- Grant and rvalid in the same cycle: push and pop both occur; outstanding unchanged.
- Grant while the FIFO is full cannot happen (req is gated by the outstanding count).

Test Plan:
1. Sequential, single slot:
   - Setup: MAX_OUTSTANDING=1, N_TRANS=4, mode 00, base 0x100, gnt always 1, rvalid 2 cycles after gnt with golden data.
   - Required: addrs 0x100, 0x110, 0x120, 0x130; never 2 in flight; eoc_o=1 after the 4th rvalid; err_cnt=0.
2. Wrap:
   - Setup: mode 00, base 0xFF0, ADDR_MASK 0xFF0, N_TRANS=3.
   - Required: addrs 0xFF0, 0x000, 0x010.
3. Pipelined:
   - Setup: MAX_OUTSTANDING=4, N_TRANS=16, gnt=1, rvalid delay 6 cycles.
   - Required: req drops while outstanding=4; at most 4 in flight; trans_cnt=resp_cnt=16; eoc_o=1.
4. Handshake hold:
   - Setup: gnt held low 5 cycles; fetch_enable_i dropped in cycle 2.
   - Required: req and addr stable until gnt; no new req after the grant until enable returns.
5. Errors:
   - Setup: corrupt word 2 of the 3rd response; inject 1 rvalid with nothing outstanding.
   - Required: err_cnt=2; err_o=1 from the first error.
6. Random / mixed / reset:
   - Mode 01 with seed 32'hACE1_2345: first addr = LFSR_SEED & 0xFF0 = 0x340; every addr & ~0xFF0 == 0.
   - Mode 10: random jumps occur exactly when LFSR[3:0]==0.
   - Reset asserted mid-DRAIN: all outputs return to reset values immediately.

Source files
------------

// File: rtl/tgen_fetch_ot.sv
// Fetch-side traffic generator: issues sequential, LFSR-random or mixed fetch requests
// with up to MAX_OUTSTANDING in flight and checks each returned line against its address.
module tgen_fetch_ot #(
  parameter int unsigned FETCH_ADDR_WIDTH = 32,
  parameter int unsigned FETCH_DATA_WIDTH = 128,
  parameter int unsigned MAX_OUTSTANDING  = 4,
  parameter int unsigned N_TRANS          = 1024,
  parameter logic [31:0] ADDR_MASK        = 32'h0000_0FF0,
  parameter logic [31:0] LFSR_SEED        = 32'hACE1_2345
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        fetch_enable_i,
  input  logic [1:0]                  mode_i,
  input  logic [FETCH_ADDR_WIDTH-1:0] base_addr_i,
  output logic                        fetch_req_o,
  output logic [FETCH_ADDR_WIDTH-1:0] fetch_addr_o,
  input  logic                        fetch_gnt_i,
  input  logic                        fetch_rvalid_i,
  input  logic [FETCH_DATA_WIDTH-1:0] fetch_rdata_i,
  output logic [31:0]                 trans_cnt_o,
  output logic [31:0]                 resp_cnt_o,
  output logic [15:0]                 err_cnt_o,
  output logic                        err_o,
  output logic                        eoc_o,
  output logic                        busy_o
);
  localparam int unsigned AW     = FETCH_ADDR_WIDTH;
  localparam int unsigned DW     = FETCH_DATA_WIDTH;
  localparam int unsigned BYTES  = DW / 8;
  localparam int          NWORDS = int'(DW / 32);
  localparam int unsigned PW     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW     = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [AW-1:0] MASK_A = AW'(ADDR_MASK);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  function automatic logic [AW-1:0] wrap_next(input logic [AW-1:0] a);
    logic [AW-1:0] inc;
    inc = a + AW'(BYTES);
    return (a & ~MASK_A) | (inc & MASK_A);
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Golden line: consecutive 32-bit words counting up from the line-aligned address.
  function automatic logic line_ok(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [31:0] base;
    logic        ok;
    base = 32'(a) & ~(32'(BYTES) - 32'd1);
    ok   = 1'b1;
    for (int k = 0; k < NWORDS; k++)
      if (d[32*k +: 32] != base + 32'(4 * k)) ok = 1'b0;
    return ok;
  endfunction

  state_t          r_state, w_state_nxt;
  logic            r_req, w_req_nxt;
  logic [AW-1:0]   r_addr, w_addr_nxt;
  logic [1:0]      r_mode;
  logic [31:0]     r_lfsr, w_lfsr_nxt;
  logic [31:0]     r_trans, r_resp;
  logic [15:0]     r_err_cnt;
  logic            r_err, r_eoc;
  logic [AW-1:0]   r_fifo [MAX_OUTSTANDING];
  logic [PW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_out;
  logic            w_fire, w_empty, w_pop, w_bad, w_last, w_slot, w_more, w_start;

  assign w_fire     = r_req & fetch_gnt_i;
  assign w_empty    = (r_out == '0);
  assign w_pop      = fetch_rvalid_i & ~w_empty;
  assign w_bad      = fetch_rvalid_i & (w_empty | ~line_ok(r_fifo[r_rptr], fetch_rdata_i));
  assign w_last     = w_fire & (r_trans == 32'(N_TRANS - 1));
  assign w_start    = (r_state == S_IDLE) & fetch_enable_i;
  assign w_lfsr_nxt = lfsr_step(r_lfsr);
  // A grant taken this cycle occupies a slot; a response this cycle frees one only next cycle.
  assign w_slot     = (32'(r_out) + 32'(w_fire)) < 32'(MAX_OUTSTANDING);
  assign w_more     = (r_trans + 32'(w_fire)) < 32'(N_TRANS);
  assign w_req_nxt  = (r_req & ~fetch_gnt_i) |
                      ((r_state == S_RUN) & fetch_enable_i & w_more & w_slot);

  always_comb begin
    w_addr_nxt = wrap_next(r_addr);
    if (r_mode == 2'b01)
      w_addr_nxt = AW'(w_lfsr_nxt) & MASK_A;
    else if ((r_mode == 2'b10) && (w_lfsr_nxt[3:0] == 4'd0))
      w_addr_nxt = AW'(w_lfsr_nxt) & MASK_A;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (fetch_enable_i) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_empty) w_state_nxt = S_DONE;
      default: w_state_nxt = S_DONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_req     <= 1'b0;
      r_addr    <= '0;
      r_mode    <= 2'b00;
      r_lfsr    <= LFSR_SEED;
      r_trans   <= '0;
      r_resp    <= '0;
      r_err_cnt <= '0;
      r_err     <= 1'b0;
      r_eoc     <= 1'b0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_out     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_eoc   <= r_eoc | (w_state_nxt == S_DONE);
      if (w_start) begin
        r_mode <= (mode_i == 2'b11) ? 2'b00 : mode_i;
        r_addr <= (mode_i == 2'b01) ? (AW'(r_lfsr) & MASK_A) : base_addr_i;
      end else if (w_fire) begin
        r_addr <= w_addr_nxt;
      end
      if (w_fire) begin
        r_lfsr  <= w_lfsr_nxt;
        r_trans <= r_trans + 32'd1;
        r_wptr  <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_resp <= r_resp + 32'd1;
        r_rptr <= ptr_inc(r_rptr);
      end
      if (w_fire && !w_pop)
        r_out <= r_out + 1'b1;
      else if (!w_fire && w_pop)
        r_out <= r_out - 1'b1;
      if (w_bad) begin
        if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire) r_fifo[r_wptr] <= r_addr;
  end

  assign fetch_req_o  = r_req;
  assign fetch_addr_o = r_addr;
  assign trans_cnt_o  = r_trans;
  assign resp_cnt_o   = r_resp;
  assign err_cnt_o    = r_err_cnt;
  assign err_o        = r_err;
  assign eoc_o        = r_eoc;
  assign busy_o       = (r_state == S_RUN) | (r_state == S_DRAIN);
endmodule

// File: tb/tb_tgen_fetch_ot.sv
// Directed bench for tgen_fetch_ot: a memory responder grants and returns golden lines
// after a programmable delay while the main sequence runs each scenario.
module tb_tgen_fetch_ot;
  localparam int          NT   = 32;
  localparam int          MAXO = 4;
  localparam logic [31:0] MASK = 32'h0000_0FF0;
  localparam logic [31:0] SEED = 32'hACE1_2345;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fetch_enable_i;
  logic [1:0]   mode_i;
  logic [31:0]  base_addr_i;
  logic         fetch_req_o;
  logic [31:0]  fetch_addr_o;
  logic         fetch_gnt_i;
  logic         fetch_rvalid_i;
  logic [127:0] fetch_rdata_i;
  logic [31:0]  trans_cnt_o, resp_cnt_o;
  logic [15:0]  err_cnt_o;
  logic         err_o, eoc_o, busy_o;

  always #5 clk = ~clk;

  tgen_fetch_ot #(
    .FETCH_ADDR_WIDTH(32), .FETCH_DATA_WIDTH(128), .MAX_OUTSTANDING(MAXO),
    .N_TRANS(NT), .ADDR_MASK(MASK), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fetch_enable_i(fetch_enable_i), .mode_i(mode_i),
    .base_addr_i(base_addr_i), .fetch_req_o(fetch_req_o), .fetch_addr_o(fetch_addr_o),
    .fetch_gnt_i(fetch_gnt_i), .fetch_rvalid_i(fetch_rvalid_i), .fetch_rdata_i(fetch_rdata_i),
    .trans_cnt_o(trans_cnt_o), .resp_cnt_o(resp_cnt_o), .err_cnt_o(err_cnt_o),
    .err_o(err_o), .eoc_o(eoc_o), .busy_o(busy_o)
  );

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] q_addr[$];
  int          q_due[$];
  logic [31:0] log_addr[$];
  int          cyc, inflight, max_inflight, full_req_viol, resp_idx;
  int          tb_delay, tb_corrupt;
  bit          tb_gnt_en, tb_inject;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] golden(input logic [31:0] a);
    logic [127:0] g;
    for (int k = 0; k < 4; k++) g[32*k +: 32] = (a & 32'hFFFF_FFF0) + 32'(4 * k);
    return g;
  endfunction

  function automatic logic [31:0] m_step(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  function automatic logic [31:0] m_wrap(input logic [31:0] a);
    return (a & ~MASK) | ((a + 32'd16) & MASK);
  endfunction

  // Memory model: decides grant and response for the coming rising edge at each falling edge.
  task automatic responder();
    logic [31:0]  a;
    logic [127:0] d;
    forever begin
      @(negedge clk);
      cyc++;
      fetch_rvalid_i = 1'b0;
      fetch_rdata_i  = '0;
      if (!rst_n) begin
        fetch_gnt_i = 1'b0;
        continue;
      end
      if (inflight >= MAXO && fetch_req_o) full_req_viol++;
      fetch_gnt_i = tb_gnt_en;
      if (fetch_req_o && fetch_gnt_i) begin
        q_addr.push_back(fetch_addr_o);
        q_due.push_back(cyc + tb_delay);
        log_addr.push_back(fetch_addr_o);
        inflight++;
      end
      if (q_due.size() > 0 && q_due[0] <= cyc) begin
        a = q_addr.pop_front();
        void'(q_due.pop_front());
        d = golden(a);
        if (resp_idx == tb_corrupt) d[64 +: 32] = d[64 +: 32] ^ 32'h0000_0100;
        resp_idx++;
        fetch_rvalid_i = 1'b1;
        fetch_rdata_i  = d;
        inflight--;
      end else if (tb_inject) begin
        fetch_rvalid_i = 1'b1;
        fetch_rdata_i  = 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978;
        tb_inject      = 1'b0;
      end
      if (inflight > max_inflight) max_inflight = inflight;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    fetch_enable_i = 1'b0;
    tb_gnt_en = 1'b0;
    tb_inject = 1'b0;
    tb_corrupt = -1;
    repeat (2) @(negedge clk);
    #1;
    q_addr.delete();
    q_due.delete();
    log_addr.delete();
    inflight = 0;
    max_inflight = 0;
    full_req_viol = 0;
    resp_idx = 0;
    rst_n = 1'b1;
  endtask

  task automatic start_run(input logic [1:0] m, input logic [31:0] b, input int dly, input bit g);
    @(negedge clk);
    #1;
    mode_i = m;
    base_addr_i = b;
    tb_delay = dly;
    tb_gnt_en = g;
    fetch_enable_i = 1'b1;
  endtask

  task automatic wait_eoc(input string tag);
    for (int i = 0; i < 4000 && !eoc_o; i++) @(negedge clk);
    chk(tag, eoc_o, 1);
  endtask

  initial begin
    logic [31:0] l, a, held;
    int          cnt;
    rst_n = 1'b0; fetch_enable_i = 1'b0; mode_i = 2'b00; base_addr_i = '0;
    fetch_gnt_i = 1'b0; fetch_rvalid_i = 1'b0; fetch_rdata_i = '0;
    tb_gnt_en = 1'b0; tb_inject = 1'b0; tb_corrupt = -1; tb_delay = 2;
    cyc = 0; inflight = 0; max_inflight = 0; full_req_viol = 0; resp_idx = 0;
    fork responder(); join_none

    repeat (3) @(negedge clk);
    chk("rst_req", fetch_req_o, 0);
    chk("rst_addr", fetch_addr_o, 0);
    chk("rst_trans", trans_cnt_o, 0);
    chk("rst_resp", resp_cnt_o, 0);
    chk("rst_errcnt", err_cnt_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_eoc", eoc_o, 0);
    chk("rst_busy", busy_o, 0);

    // Sequential stream
    do_reset();
    start_run(2'b00, 32'h0000_0100, 2, 1'b1);
    wait_eoc("seq_eoc");
    chk("seq_n", log_addr.size(), NT);
    for (int i = 0; i < NT; i++) chk("seq_addr", log_addr[i], 32'h100 + 32'(16 * i));
    chk("seq_trans", trans_cnt_o, NT);
    chk("seq_resp", resp_cnt_o, NT);
    chk("seq_errcnt", err_cnt_o, 0);
    chk("seq_busy", busy_o, 0);
    chk("seq_max_le4", max_inflight <= MAXO, 1);

    // Wrap within the mask, upper bits preserved
    do_reset();
    start_run(2'b00, 32'h1234_5FF0, 1, 1'b1);
    wait_eoc("wrap_eoc");
    chk("wrap_a0", log_addr[0], 32'h1234_5FF0);
    chk("wrap_a1", log_addr[1], 32'h1234_5000);
    chk("wrap_a2", log_addr[2], 32'h1234_5010);
    for (int i = 3; i < NT; i++)
      chk("wrap_addr", log_addr[i], 32'h1234_5000 | ((32'hFF0 + 32'(16 * i)) & 32'hFF0));
    chk("wrap_errcnt", err_cnt_o, 0);

    // Pipelined, long response latency
    do_reset();
    start_run(2'b00, 32'h0, 6, 1'b1);
    wait_eoc("pipe_eoc");
    chk("pipe_max", max_inflight, MAXO);
    chk("pipe_req_at_full", full_req_viol, 0);
    chk("pipe_trans", trans_cnt_o, NT);
    chk("pipe_resp", resp_cnt_o, NT);
    chk("pipe_errcnt", err_cnt_o, 0);

    // Handshake hold with enable dropped during the stall
    do_reset();
    start_run(2'b00, 32'h0000_0200, 2, 1'b0);
    for (int i = 0; i < 20 && !fetch_req_o; i++) @(negedge clk);
    #1;
    held = fetch_addr_o;
    chk("hold_req", fetch_req_o, 1);
    chk("hold_addr0", held, 32'h200);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if (i == 1) fetch_enable_i = 1'b0;
      if (!fetch_req_o || fetch_addr_o != held) cnt++;
    end
    chk("hold_stable", cnt, 0);
    tb_gnt_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("hold_trans", trans_cnt_o, 1);
    chk("hold_next_addr", fetch_addr_o, 32'h210);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if (fetch_req_o) cnt++;
    end
    chk("hold_paused", cnt, 0);
    fetch_enable_i = 1'b1;
    wait_eoc("hold_eoc");
    chk("hold_trans_end", trans_cnt_o, NT);
    chk("hold_errcnt", err_cnt_o, 0);

    // Errors: unexpected response, corrupted line, response after end of test
    do_reset();
    tb_inject = 1'b1;
    repeat (3) @(negedge clk);
    chk("err_unexp_cnt", err_cnt_o, 1);
    chk("err_unexp_flag", err_o, 1);
    tb_corrupt = 2;
    start_run(2'b00, 32'h0000_0300, 2, 1'b1);
    wait_eoc("err_eoc");
    chk("err_cnt_run", err_cnt_o, 2);
    chk("err_flag", err_o, 1);
    #1;
    tb_inject = 1'b1;
    repeat (3) @(negedge clk);
    chk("err_done_cnt", err_cnt_o, 3);
    chk("err_done_eoc", eoc_o, 1);

    // Random mode
    do_reset();
    start_run(2'b01, 32'hDEAD_0000, 3, 1'b1);
    wait_eoc("rnd_eoc");
    chk("rnd_a0", log_addr[0], 32'h340);
    chk("rnd_a1", log_addr[1], 32'h680);
    l = SEED;
    cnt = 0;
    for (int i = 0; i < NT; i++) begin
      chk("rnd_addr", log_addr[i], l & MASK);
      if ((log_addr[i] & ~MASK) != 0) cnt++;
      l = m_step(l);
    end
    chk("rnd_outside_mask", cnt, 0);
    chk("rnd_errcnt", err_cnt_o, 0);

    // Mixed mode
    do_reset();
    start_run(2'b10, 32'h0000_0100, 2, 1'b1);
    wait_eoc("mix_eoc");
    l = SEED;
    a = 32'h100;
    for (int i = 0; i < NT; i++) begin
      chk("mix_addr", log_addr[i], a);
      l = m_step(l);
      a = (l[3:0] == 4'd0) ? (l & MASK) : m_wrap(a);
    end
    chk("mix_errcnt", err_cnt_o, 0);

    // Mode 11 behaves as sequential
    do_reset();
    start_run(2'b11, 32'h0000_0500, 2, 1'b1);
    wait_eoc("m3_eoc");
    chk("m3_a0", log_addr[0], 32'h500);
    chk("m3_a1", log_addr[1], 32'h510);

    // Asynchronous reset in the middle of DRAIN
    do_reset();
    start_run(2'b00, 32'h0000_0400, 20, 1'b1);
    for (int i = 0; i < 3000 && trans_cnt_o != NT; i++) @(negedge clk);
    chk("drn_trans", trans_cnt_o, NT);
    chk("drn_busy", busy_o, 1);
    chk("drn_eoc", eoc_o, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("drn_rst_req", fetch_req_o, 0);
    chk("drn_rst_addr", fetch_addr_o, 0);
    chk("drn_rst_trans", trans_cnt_o, 0);
    chk("drn_rst_resp", resp_cnt_o, 0);
    chk("drn_rst_errcnt", err_cnt_o, 0);
    chk("drn_rst_busy", busy_o, 0);
    chk("drn_rst_eoc", eoc_o, 0);
    do_reset();
    repeat (4) @(negedge clk);
    chk("post_rst_busy", busy_o, 0);
    chk("post_rst_req", fetch_req_o, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
